// File: rtl/imm_pkg.sv
// Shared constants for the immediate-generation stage: one-hot format
// indices and the base/RV64 opcodes recognised by the decoder.
package imm_pkg;

   localparam int FMT_W = 7;

   localparam int FMT_R = 0;
   localparam int FMT_I = 1;
   localparam int FMT_S = 2;
   localparam int FMT_B = 3;
   localparam int FMT_U = 4;
   localparam int FMT_J = 5;
   localparam int FMT_Z = 6;

   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_OP32    = 7'b0111011;

endpackage

// File: rtl/imm_decode_pipe_if.sv
// Fetch-side and decode-side handshake bundle of the immediate stage.
// slave is the stage itself, master is whatever drives and drains it.
interface imm_decode_pipe_if
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
) ();

   logic             i_valid;
   logic             o_ready;
   logic [31:0]      i_inst;
   logic [TAG_W-1:0] i_tag;
   logic             o_valid;
   logic             i_ready;
   logic [XLEN-1:0]  o_immediate;
   logic [FMT_W-1:0] o_format;
   logic             o_illegal;
   logic [TAG_W-1:0] o_tag;

   modport slave (
      input  i_valid, i_inst, i_tag, i_ready,
      output o_ready, o_valid, o_immediate, o_format, o_illegal, o_tag
   );

   modport master (
      output i_valid, i_inst, i_tag, i_ready,
      input  o_ready, o_valid, o_immediate, o_format, o_illegal, o_tag
   );

endinterface

// File: rtl/imm_decode_comb.sv
// Purely combinational opcode-to-format decode and immediate assembly.
module imm_decode_comb
   import imm_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter bit EN_ZIMM = 1'b1
) (
   input  logic [31:0]      inst,
   output logic [FMT_W-1:0] fmt,
   output logic             illegal,
   output logic [XLEN-1:0]  immediate
);

   logic [31:0] imm32;

   always_comb begin
      fmt     = '0;
      illegal = 1'b0;
      case (inst[6:0])
         OPC_OP:                        fmt[FMT_R] = 1'b1;
         OPC_OPIMM, OPC_LOAD, OPC_JALR: fmt[FMT_I] = 1'b1;
         OPC_STORE:                     fmt[FMT_S] = 1'b1;
         OPC_BRANCH:                    fmt[FMT_B] = 1'b1;
         OPC_LUI, OPC_AUIPC:            fmt[FMT_U] = 1'b1;
         OPC_JAL:                       fmt[FMT_J] = 1'b1;
         OPC_SYSTEM: begin
            // CSR immediate forms carry a 5-bit zimm in the rs1 field
            if (EN_ZIMM && inst[14]) fmt[FMT_Z] = 1'b1;
            else                     fmt[FMT_I] = 1'b1;
         end
         OPC_OPIMM32: begin
            if (XLEN == 64) fmt[FMT_I] = 1'b1;
            else            illegal    = 1'b1;
         end
         OPC_OP32: begin
            if (XLEN == 64) fmt[FMT_R] = 1'b1;
            else            illegal    = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      imm32 = '0;
      if (fmt[FMT_I])      imm32 = {{20{inst[31]}}, inst[31:20]};
      else if (fmt[FMT_S]) imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      else if (fmt[FMT_B]) imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      else if (fmt[FMT_U]) imm32 = {inst[31:12], 12'b0};
      else if (fmt[FMT_J]) imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      else if (fmt[FMT_Z]) imm32 = {27'b0, inst[19:15]};
   end

   // Every 32-bit form is already sign-correct, so widening is a plain sign extend
   assign immediate = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_decode_pipe.sv
// Registered immediate-generation stage: decode ahead of a one-entry
// output register backed by a one-entry skid register.
module imm_decode_pipe
   import imm_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TAG_W   = 8,
   parameter bit EN_ZIMM = 1'b1
) (
   input logic               i_clk,
   input logic               i_rst,
   imm_decode_pipe_if.slave  bus
);

   // Handshake: a side transfers on a clock edge where its valid and ready are
   // both 1; valid never depends on ready, and a stalled output holds steady.

   logic [FMT_W-1:0] dec_fmt;
   logic             dec_ill;
   logic [XLEN-1:0]  dec_imm;

   logic             out_valid, skid_valid, ready_q;
   logic [XLEN-1:0]  out_imm, skid_imm;
   logic [FMT_W-1:0] out_fmt, skid_fmt;
   logic             out_ill, skid_ill;
   logic [TAG_W-1:0] out_tag, skid_tag;

   logic in_fire, out_free;

   imm_decode_comb #(.XLEN(XLEN), .EN_ZIMM(EN_ZIMM)) u_dec (
      .inst      (bus.i_inst),
      .fmt       (dec_fmt),
      .illegal   (dec_ill),
      .immediate (dec_imm)
   );

   assign in_fire  = bus.i_valid && ready_q;
   assign out_free = !out_valid || bus.i_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         ready_q    <= 1'b0;
         out_imm    <= '0;
         out_fmt    <= '0;
         out_ill    <= 1'b0;
         out_tag    <= '0;
         skid_imm   <= '0;
         skid_fmt   <= '0;
         skid_ill   <= 1'b0;
         skid_tag   <= '0;
      end else begin
         ready_q <= !skid_valid;
         if (out_free) begin
            // A full skid implies ready was low, so no new input competes here
            if (skid_valid) begin
               out_valid  <= 1'b1;
               out_imm    <= skid_imm;
               out_fmt    <= skid_fmt;
               out_ill    <= skid_ill;
               out_tag    <= skid_tag;
               skid_valid <= 1'b0;
               ready_q    <= 1'b1;
            end else begin
               out_valid <= in_fire;
               if (in_fire) begin
                  out_imm <= dec_imm;
                  out_fmt <= dec_fmt;
                  out_ill <= dec_ill;
                  out_tag <= bus.i_tag;
               end
            end
         end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_imm   <= dec_imm;
            skid_fmt   <= dec_fmt;
            skid_ill   <= dec_ill;
            skid_tag   <= bus.i_tag;
            ready_q    <= 1'b0;
         end
      end
   end

   assign bus.o_ready     = ready_q;
   assign bus.o_valid     = out_valid;
   assign bus.o_immediate = out_imm;
   assign bus.o_format    = out_fmt;
   assign bus.o_illegal   = out_ill;
   assign bus.o_tag       = out_tag;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Directed bench for imm_decode_pipe: reset, format decode, zimm/RV64 variants,
// backpressure ordering, full-rate streaming and mid-stream reset.
module tb_imm_decode_pipe;

   logic clk;
   logic rst;

   int vectors     = 0;
   int miscompares = 0;
   int out_cnt     = 0;

   // {illegal, format, tag, immediate}
   logic [47:0] exp_q[$];

   localparam logic [31:0] FV_INST [7] = '{32'hFFF00093, 32'hFE000EE3, 32'h800000EF, 32'h00000000,
                                           32'hFE112E23, 32'h12345017, 32'h00B50533};
   localparam logic [31:0] FV_IMM  [7] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFF00000, 32'h00000000,
                                           32'hFFFFFFFC, 32'h12345000, 32'h00000000};
   localparam logic [6:0]  FV_FMT  [7] = '{7'b0000010, 7'b0001000, 7'b0100000, 7'b0000000,
                                           7'b0000100, 7'b0010000, 7'b0000001};
   localparam logic        FV_ILL  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam logic [6:0]  OPC_TAB [12] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                                            7'h37, 7'h17, 7'h6F, 7'h73, 7'h1B, 7'h7F};

   imm_decode_pipe_if #(.XLEN(32), .TAG_W(8)) bp  ();
   imm_decode_pipe_if #(.XLEN(32), .TAG_W(8)) bnz ();
   imm_decode_pipe_if #(.XLEN(64), .TAG_W(8)) b64 ();

   imm_decode_pipe #(.XLEN(32), .TAG_W(8), .EN_ZIMM(1'b1)) u_dut (
      .i_clk (clk), .i_rst (rst), .bus (bp.slave));
   imm_decode_pipe #(.XLEN(32), .TAG_W(8), .EN_ZIMM(1'b0)) u_dut_nz (
      .i_clk (clk), .i_rst (rst), .bus (bnz.slave));
   imm_decode_pipe #(.XLEN(64), .TAG_W(8), .EN_ZIMM(1'b1)) u_dut64 (
      .i_clk (clk), .i_rst (rst), .bus (b64.slave));

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "timeout");
   end

   // Reference decode for XLEN=32, EN_ZIMM=1
   function automatic void ref_dec(input logic [31:0] inst, output logic [31:0] imm,
                                   output logic [6:0] fmt, output logic ill);
      logic [6:0] op;
      op  = inst[6:0];
      fmt = 7'b0;
      ill = 1'b0;
      imm = 32'h0;
      case (op)
         7'h33:               fmt = 7'b0000001;
         7'h13, 7'h03, 7'h67: fmt = 7'b0000010;
         7'h23:               fmt = 7'b0000100;
         7'h63:               fmt = 7'b0001000;
         7'h37, 7'h17:        fmt = 7'b0010000;
         7'h6F:               fmt = 7'b0100000;
         7'h73:               fmt = inst[14] ? 7'b1000000 : 7'b0000010;
         default:             ill = 1'b1;
      endcase
      case (fmt)
         7'b0000010: imm = $signed(inst) >>> 20;
         7'b0000100: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         7'b0001000: imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
         7'b0010000: imm = inst & 32'hFFFFF000;
         7'b0100000: imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
         7'b1000000: imm = {27'd0, inst[19:15]};
         default:    imm = 32'h0;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   // driver step with scoreboard: retire the output transfer, record the input transfer, advance one cycle
   task automatic step();
      logic [47:0] e;
      logic [31:0] imm;
      logic [6:0]  fmt;
      logic        ill;
      if (bp.o_valid && bp.i_ready) begin
         out_cnt++;
         vectors++;
         assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL sb_extra: observed output tag %0h expected no output", bp.o_tag);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_tag", 64'(bp.o_tag), 64'(e[39:32]));
            check("sb_imm", 64'(bp.o_immediate), 64'(e[31:0]));
            check("sb_fmt", 64'(bp.o_format), 64'(e[46:40]));
            check("sb_ill", 64'(bp.o_illegal), 64'(e[47]));
         end
      end
      if (bp.i_valid && bp.o_ready) begin
         ref_dec(bp.i_inst, imm, fmt, ill);
         exp_q.push_back({ill, fmt, bp.i_tag, imm});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      bp.i_valid  = 1'b1;  bp.i_inst  = 32'hFFF00093; bp.i_tag  = 8'h0; bp.i_ready  = 1'b1;
      bnz.i_valid = 1'b0;  bnz.i_inst = 32'h0;        bnz.i_tag = 8'h0; bnz.i_ready = 1'b1;
      b64.i_valid = 1'b0;  b64.i_inst = 32'h0;        b64.i_tag = 8'h0; b64.i_ready = 1'b1;

      // reset behaviour
      @(posedge clk);
      #1;
      check("rst_valid", 64'(bp.o_valid), 64'd0);
      check("rst_ready", 64'(bp.o_ready), 64'd0);
      check("rst_imm",   64'(bp.o_immediate), 64'd0);
      check("rst_fmt",   64'(bp.o_format), 64'd0);
      check("rst_tag",   64'(bp.o_tag), 64'd0);
      check("rst_ill",   64'(bp.o_illegal), 64'd0);
      bp.i_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("rel_ready_pre", 64'(bp.o_ready), 64'd0);
      @(posedge clk);
      #1;
      check("rel_ready", 64'(bp.o_ready), 64'd1);
      check("rel_valid", 64'(bp.o_valid), 64'd0);

      // format vectors, downstream always ready
      for (int k = 0; k < 7; k++) begin
         bp.i_valid = 1'b1;
         bp.i_inst  = FV_INST[k];
         bp.i_tag   = 8'(k + 1);
         step();
         check("fv_valid", 64'(bp.o_valid), 64'd1);
         check("fv_imm",   64'(bp.o_immediate), 64'(FV_IMM[k]));
         check("fv_fmt",   64'(bp.o_format), 64'(FV_FMT[k]));
         check("fv_ill",   64'(bp.o_illegal), 64'(FV_ILL[k]));
         check("fv_tag",   64'(bp.o_tag), 64'(k + 1));
      end
      bp.i_valid = 1'b0;
      step();
      check("fv_drain", 64'(bp.o_valid), 64'd0);

      // zimm enabled/disabled and RV64 sign extension
      bp.i_valid  = 1'b1; bp.i_inst  = 32'h3400F073; bp.i_tag = 8'h30;
      bnz.i_valid = 1'b1; bnz.i_inst = 32'h3400F073;
      b64.i_valid = 1'b1; b64.i_inst = 32'h800002B7;
      step();
      check("zimm_fmt",  64'(bp.o_format), 64'h40);
      check("zimm_imm",  64'(bp.o_immediate), 64'h1);
      check("nz_fmt",    64'(bnz.o_format), 64'h02);
      check("nz_imm",    64'(bnz.o_immediate), 64'h340);
      check("rv64_lui",  b64.o_immediate, 64'hFFFF_FFFF_8000_0000);
      check("rv64_fmtu", 64'(b64.o_format), 64'h10);
      bp.i_valid  = 1'b1; bp.i_inst = 32'hFFF0009B; bp.i_tag = 8'h31;
      bnz.i_valid = 1'b0;
      b64.i_inst  = 32'hFFF0009B;
      step();
      check("rv32_w_ill", 64'(bp.o_illegal), 64'd1);
      check("rv32_w_imm", 64'(bp.o_immediate), 64'd0);
      check("rv64_w_imm", b64.o_immediate, 64'hFFFF_FFFF_FFFF_FFFF);
      check("rv64_w_fmt", 64'(b64.o_format), 64'h02);
      check("rv64_w_ill", 64'(b64.o_illegal), 64'd0);
      bp.i_valid  = 1'b0;
      b64.i_valid = 1'b0;
      step();

      // backpressure: downstream stalls for three edges
      bp.i_ready = 1'b0;
      bp.i_valid = 1'b1; bp.i_inst = 32'h00100093; bp.i_tag = 8'd1;
      step();
      check("bp_ready1", 64'(bp.o_ready), 64'd1);
      check("bp_tag1",   64'(bp.o_tag), 64'd1);
      bp.i_inst = 32'h00200093; bp.i_tag = 8'd2;
      step();
      check("bp_ready2", 64'(bp.o_ready), 64'd0);
      check("bp_hold1",  64'(bp.o_tag), 64'd1);
      bp.i_inst = 32'h00300093; bp.i_tag = 8'd3;
      step();
      check("bp_ready3", 64'(bp.o_ready), 64'd0);
      check("bp_hold2",  64'(bp.o_tag), 64'd1);
      check("bp_himm",   64'(bp.o_immediate), 64'd1);
      bp.i_ready = 1'b1;
      step();
      check("bp_skid_out", 64'(bp.o_tag), 64'd2);
      check("bp_reopen",   64'(bp.o_ready), 64'd1);
      step();
      check("bp_tag3", 64'(bp.o_tag), 64'd3);
      bp.i_inst = 32'h00400093; bp.i_tag = 8'd4;
      step();
      check("bp_tag4", 64'(bp.o_tag), 64'd4);
      bp.i_valid = 1'b0;
      step();
      check("bp_drain", 64'(bp.o_valid), 64'd0);
      check("bp_empty", 64'(exp_q.size()), 64'd0);

      // full throughput with random instructions
      out_cnt = 0;
      bp.i_valid = 1'b1;
      for (int k = 0; k < 16; k++) begin
         logic [31:0] r;
         int          idx;
         r   = $urandom();
         idx = $urandom_range(0, 11);
         bp.i_inst = {r[31:7], OPC_TAB[idx]};
         bp.i_tag  = 8'(8'h40 + k);
         step();
         check("tp_valid", 64'(bp.o_valid), 64'd1);
         check("tp_tag",   64'(bp.o_tag), 64'(8'h40 + k));
      end
      bp.i_valid = 1'b0;
      step();
      check("tp_count", 64'(out_cnt), 64'd16);
      check("tp_empty", 64'(exp_q.size()), 64'd0);

      // reset asserted between edges with both registers full
      bp.i_ready = 1'b0;
      bp.i_valid = 1'b1; bp.i_inst = 32'h00500093; bp.i_tag = 8'h21;
      step();
      bp.i_tag = 8'h22;
      step();
      check("mr_full", 64'(bp.o_ready), 64'd0);
      #2;
      rst = 1'b1;
      #1;
      check("mr_valid", 64'(bp.o_valid), 64'd0);
      check("mr_ready", 64'(bp.o_ready), 64'd0);
      check("mr_tag",   64'(bp.o_tag), 64'd0);
      exp_q.delete();
      bp.i_valid = 1'b0;
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("mr_reopen", 64'(bp.o_ready), 64'd1);
      check("mr_empty",  64'(bp.o_valid), 64'd0);
      bp.i_ready = 1'b1;
      bp.i_valid = 1'b1; bp.i_inst = 32'h00600093; bp.i_tag = 8'h23;
      step();
      check("mr_post_valid", 64'(bp.o_valid), 64'd1);
      check("mr_post_tag",   64'(bp.o_tag), 64'h23);
      check("mr_post_imm",   64'(bp.o_immediate), 64'd6);
      bp.i_valid = 1'b0;
      step();
      check("mr_post_drain", 64'(bp.o_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/imm_decode_pipe.md
Name: imm_decode_pipe

Overview:
- Registered, parametrised immediate-generation stage that sits between fetch and the decoder/register-read stage.
- Derives the instruction format from the opcode itself; no format input from upstream.
- Emits an XLEN-wide sign-extended immediate, a one-hot format, and an illegal-opcode flag.
- Valid/ready handshake on both sides, backed by a 2-entry skid buffer for full throughput under backpressure; optionally supports the CSR zimm format.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64. XLEN=64 additionally decodes OP-IMM-32 (0011011) as I and OP-32 (0111011) as R.
- TAG_W, 8, width of the opaque sideband tag (e.g. PC index) carried alongside each instruction.
- EN_ZIMM, 1, when 1 SYSTEM instructions with funct3[2]=1 decode as Z format; when 0 they decode as I.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage can accept an instruction this cycle
- i_inst  in  32  instruction word
- i_tag  in  TAG_W  sideband tag
- o_valid  out  1  output entry valid
- i_ready  in  1  downstream accepts the output this cycle
- o_immediate  out  XLEN  sign-extended immediate
- o_format  out  7  one-hot format: [0]R [1]I [2]S [3]B [4]U [5]J [6]Z
- o_illegal  out  1  opcode not recognised
- o_tag  out  TAG_W  tag of the output entry

Behaviour:
- Reset is asynchronous and active-high. While i_rst=1:
  - o_valid=0, skid entry invalid, o_ready=0.
  - o_immediate, o_format, o_tag and o_illegal all 0.
  - After deassertion, o_ready=1 from the first clock edge onward.
- Opcode decode (i_inst[6:0]):
  - 0110011 → R
  - 0010011, 0000011, 1100111 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - 1110011 → Z if EN_ZIMM and funct3[2]=1, else I
  - XLEN=64 extras: 0011011 → I, 0111011 → R
  - Any other opcode: o_format=0, o_illegal=1, o_immediate=0.
- Immediates are sign-extended from inst[31] to XLEN:
  - I = inst[31:20]
  - S = {inst[31:25], inst[11:7]}
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U = {inst[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - Z = zero-extended inst[19:15]
  - R = 0 (defined, not don't-care)
- Handshake and latency:
  - An input transfer happens when i_valid && o_ready. An output transfer happens when o_valid && i_ready.
  - Latency is exactly 1 cycle: an input accepted at edge N is visible on the outputs after edge N, provided the output register is empty or draining.
  - Throughput is 1 per cycle when i_ready is held at 1.
- Skid buffer:
  - o_ready = !skid_valid, and is a registered signal.
  - If the input is accepted while the output register holds an entry and i_ready=0, the decoded entry goes to the skid register.
  - On the next output transfer, the skid entry moves to the output register and skid_valid clears.
- Simultaneous input and output transfer with an empty skid: the new entry goes directly to the output register and o_valid stays 1.
- Outputs stay stable while o_valid=1 && i_ready=0.
- Ordering is strictly FIFO; no entry may be dropped or duplicated.
- Reset asserted mid-stream discards both entries immediately, with no clock needed.
- i_inst and i_tag are ignored whenever no input transfer takes place.

Decomposition:
- Shared package imm_pkg:
  - format index constants FMT_R..FMT_Z and the width FMT_W=7
  - opcode localparams OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM, OPC_OPIMM32, OPC_OP32
- One combinational sub-module, imm_decode_comb (inst → format, illegal, immediate; parametrised by XLEN and EN_ZIMM), instantiated once ahead of the skid/output registers.

Test Plan:
- Reset: i_rst=1 with i_valid=1 → o_valid=0, o_ready=0, o_immediate=0. After release, o_ready=1 on the first edge.
- Formats, XLEN=32, i_ready=1:
  - 0xFFF00093 (addi -1) → imm 0xFFFFFFFF, fmt 0000010
  - 0xFE000EE3 (beq -4) → imm 0xFFFFFFFC, fmt 0001000
  - 0x800000EF (jal min) → imm 0xFFF00000, fmt 0100000
  - 0x00000000 → o_illegal=1, imm 0, fmt 0
- Zimm and XLEN: 0x3400F073 (csrrci, rs1=1) → Z, imm 1 (EN_ZIMM=1); I, imm 0x340 (EN_ZIMM=0). XLEN=64, 0x800002B7 (lui) → 0xFFFFFFFF80000000.
- Backpressure: stream tags 1..4 with i_ready=0 for 3 cycles → o_ready drops after 2 accepts. Releasing i_ready delivers tags 1,2,3,4 in order, no loss.
- Full throughput: i_valid=i_ready=1 for 16 cycles with random instructions → 16 outputs, each 1 cycle after its input, matching the reference decode.
- Reset mid-stream: i_rst pulsed between edges with both entries full → o_valid=0 immediately. After release, the next input is delivered cleanly.
